// File: rtl/game_flow_pkg.sv
// Shared types and limits for the game sequencer: the state/screen-mode
// encoding seen by the VGA renderer, plus small helpers.
package game_flow_pkg;

   typedef enum logic [2:0] {
      TITLE     = 3'd0,
      LOAD      = 3'd1,
      PLAY      = 3'd2,
      WIN       = 3'd3,
      LOSE      = 3'd4,
      GAME_OVER = 3'd5,
      COMPLETE  = 3'd6
   } game_state_t;

   localparam int MAX_LEVELS = 8;
   localparam int MAX_LIVES  = 7;
   localparam int DWELL_W    = 26;

   // A level index beyond the configured range behaves as the last level.
   function automatic logic [2:0] clamp_level(input logic [2:0] lvl, input logic [2:0] last);
      return (lvl > last) ? last : lvl;
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/start_edge_detector.sv
// Two-flop synchronizer for a raw board key followed by a rising-edge
// detector producing a one-cycle pulse; reusable for any push button.
module start_edge_detector (
   input  logic vga_clock,
   input  logic reset,
   input  logic button_i,
   output logic pulse_o
);

   logic       sync1_q;
   logic       sync2_q;
   logic [1:0] prime_q;
   logic       prev_q;
   logic       pulse_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the previous-cycle value of its neighbour, which is what makes
   // the synchronizer chain and edge detector behave as a pipeline.
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prime_q <= 2'b00;
         prev_q  <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= button_i;
         sync2_q <= sync1_q;
         prime_q <= {prime_q[0], 1'b1};
         // Until the chain has refilled after reset, a key held through reset
         // must not look like a fresh press.
         prev_q  <= prime_q[1] ? sync2_q : 1'b1;
         pulse_q <= sync2_q & ~prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: owns level selection, per-level reset pulses, lives,
// cleared-level count and the screen mode shown by the VGA renderer.
module game_flow_controller
   import game_flow_pkg::*;
#(
   parameter int NUM_LEVELS    = 3,
   parameter int START_LIVES   = 3,
   parameter int LOAD_CYCLES   = 4,
   parameter int SCREEN_CYCLES = 50_000_000
) (
   input  logic                  vga_clock,
   input  logic                  reset,
   input  logic                  start_button,
   input  logic [NUM_LEVELS-1:0] level_win,
   input  logic [NUM_LEVELS-1:0] level_lose,
   output logic [NUM_LEVELS-1:0] level_reset_n,
   output logic [2:0]            active_level,
   output logic [2:0]            lives,
   output logic [2:0]            screen_mode,
   output logic [3:0]            levels_cleared
);

   localparam int                 LOAD_W     = $clog2(LOAD_CYCLES);
   localparam logic [LOAD_W-1:0]  LOAD_LAST  = LOAD_W'(LOAD_CYCLES - 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCREEN_CYCLES - 1);
   localparam logic [2:0]         LAST_LEVEL = 3'(NUM_LEVELS - 1);
   localparam logic [2:0]         INIT_LIVES = 3'(START_LIVES);

   game_state_t           state_q,    state_d;
   logic [2:0]            level_q,    level_d;
   logic [2:0]            lives_q,    lives_d;
   logic [3:0]            cleared_q,  cleared_d;
   logic [LOAD_W-1:0]     load_cnt_q, load_cnt_d;
   logic [DWELL_W-1:0]    dwell_q,    dwell_d;
   logic [NUM_LEVELS-1:0] level_rst_n_q, level_rst_n_d;

   logic       start_pulse;
   logic       win_act;
   logic       lose_act;
   logic [2:0] level_idx;
   logic [2:0] level_idx_d;

   start_edge_detector u_start_edge (
      .vga_clock (vga_clock),
      .reset     (reset),
      .button_i  (start_button),
      .pulse_o   (start_pulse)
   );

   // NOTE: every register clears asynchronously, so a reset mid-game drops
   // all level resets and returns to TITLE without waiting for a clock edge.
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         state_q       <= TITLE;
         level_q       <= 3'd0;
         lives_q       <= INIT_LIVES;
         cleared_q     <= 4'd0;
         load_cnt_q    <= '0;
         dwell_q       <= '0;
         level_rst_n_q <= '0;
      end else begin
         state_q       <= state_d;
         level_q       <= level_d;
         lives_q       <= lives_d;
         cleared_q     <= cleared_d;
         load_cnt_q    <= load_cnt_d;
         dwell_q       <= dwell_d;
         level_rst_n_q <= level_rst_n_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      win_act   = 1'b0;
      lose_act  = 1'b0;
      level_idx = clamp_level(level_q, LAST_LEVEL);
      for (int i = 0; i < NUM_LEVELS; i++) begin
         if (level_idx == 3'(i)) begin
            win_act  = level_win[i];
            lose_act = level_lose[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      lives_d    = lives_q;
      cleared_d  = cleared_q;
      load_cnt_d = '0;
      dwell_d    = '0;

      unique case (state_q)
         TITLE: begin
            if (start_pulse) begin
               state_d   = LOAD;
               level_d   = 3'd0;
               lives_d   = INIT_LIVES;
               cleared_d = 4'd0;
            end
         end
         LOAD: begin
            if (load_cnt_q == LOAD_LAST) state_d = PLAY;
            else                         load_cnt_d = load_cnt_q + LOAD_W'(1);
         end
         PLAY: begin
            // dwell_q == 0 marks the first PLAY cycle, when flags may be stale.
            dwell_d = DWELL_W'(1);
            if (dwell_q != '0) begin
               if (win_act) begin
                  state_d   = WIN;
                  cleared_d = sat_inc4(cleared_q);
               end else if (lose_act && (lives_q != 3'd0)) begin
                  state_d = LOSE;
                  lives_d = lives_q - 3'd1;
               end
            end
         end
         WIN: begin
            if (dwell_q == DWELL_LAST) begin
               if (level_idx == LAST_LEVEL) begin
                  state_d = COMPLETE;
               end else begin
                  state_d = LOAD;
                  level_d = level_idx + 3'd1;
               end
            end else begin
               dwell_d = dwell_q + DWELL_W'(1);
            end
         end
         LOSE: begin
            if (dwell_q == DWELL_LAST) state_d = (lives_q == 3'd0) ? GAME_OVER : LOAD;
            else                       dwell_d = dwell_q + DWELL_W'(1);
         end
         GAME_OVER, COMPLETE: begin
            if (start_pulse) begin
               state_d   = TITLE;
               level_d   = 3'd0;
               lives_d   = INIT_LIVES;
               cleared_d = 4'd0;
            end
         end
         default: state_d = TITLE;
      endcase

      if (state_d != state_q) begin
         load_cnt_d = '0;
         dwell_d    = '0;
      end
   end

   // Level resets are computed from next state so they line up with PLAY.
   always_comb begin
      level_rst_n_d = '0;
      level_idx_d   = clamp_level(level_d, LAST_LEVEL);
      for (int i = 0; i < NUM_LEVELS; i++) begin
         level_rst_n_d[i] = (state_d == PLAY) && (level_idx_d == 3'(i));
      end
   end

   assign level_reset_n  = level_rst_n_q;
   assign active_level   = level_q;
   assign lives          = lives_q;
   assign screen_mode    = state_q;
   assign levels_cleared = cleared_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scenario bench for game_flow_controller: directed timing checks plus
// randomized games scored against a game-level reference model.
module tb_game_flow_controller;
   import game_flow_pkg::*;

   localparam int NL = 3;
   localparam int SL = 2;
   localparam int LC = 4;
   localparam int SC = 8;

   logic          vga_clock = 1'b0;
   logic          reset = 1'b0;
   logic          start_button = 1'b0;
   logic [NL-1:0] level_win = '0;
   logic [NL-1:0] level_lose = '0;
   logic [NL-1:0] level_reset_n;
   logic [2:0]    active_level;
   logic [2:0]    lives;
   logic [2:0]    screen_mode;
   logic [3:0]    levels_cleared;

   int errors = 0;
   int checks = 0;

   game_flow_controller #(
      .NUM_LEVELS    (NL),
      .START_LIVES   (SL),
      .LOAD_CYCLES   (LC),
      .SCREEN_CYCLES (SC)
   ) dut (
      .vga_clock      (vga_clock),
      .reset          (reset),
      .start_button   (start_button),
      .level_win      (level_win),
      .level_lose     (level_lose),
      .level_reset_n  (level_reset_n),
      .active_level   (active_level),
      .lives          (lives),
      .screen_mode    (screen_mode),
      .levels_cleared (levels_cleared)
   );

   always #5 vga_clock = ~vga_clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge vga_clock);
      #1;
   endtask

   task automatic wait_for_mode(input logic [2:0] m, input int budget, output bit ok);
      ok = (screen_mode === m);
      for (int i = 0; i < budget && !ok; i++) begin
         cycle();
         ok = (screen_mode === m);
      end
   endtask

   // One-cycle key press; the resulting pulse acts three edges later.
   task automatic press_start();
      start_button = 1'b1;
      cycle();
      start_button = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) cycle();
      checks++;
      if ({screen_mode, active_level, lives, level_reset_n, levels_cleared} !== {3'(TITLE), 3'd0, 3'(SL), 3'b000, 4'd0})
         begin errors++; $display("FAIL reset_hold: mode=%0d lvl=%0d lives=%0d rn=%b clr=%0d want 0/0/%0d/000/0", screen_mode, active_level, lives, level_reset_n, levels_cleared, SL); end
      reset = 1'b1;
      repeat (3) cycle();
      checks++;
      if ({screen_mode, active_level, lives, level_reset_n, levels_cleared} !== {3'(TITLE), 3'd0, 3'(SL), 3'b000, 4'd0})
         begin errors++; $display("FAIL reset_release: mode=%0d lvl=%0d lives=%0d rn=%b clr=%0d want 0/0/%0d/000/0", screen_mode, active_level, lives, level_reset_n, levels_cleared, SL); end
   endtask

   task automatic test_start_and_load();
      logic [2:0]    exp_mode;
      logic [NL-1:0] exp_rn;
      start_button = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         cycle();
         if (c == 5) start_button = 1'b0;
         exp_mode = (c < 4) ? 3'(TITLE) : (c < 4 + LC) ? 3'(LOAD) : 3'(PLAY);
         exp_rn   = (c == 8) ? 3'b001 : 3'b000;
         checks++;
         if (screen_mode !== exp_mode || level_reset_n !== exp_rn)
            begin errors++; $display("FAIL start_load c=%0d: mode=%0d rn=%b want mode=%0d rn=%b", c, screen_mode, level_reset_n, exp_mode, exp_rn); end
      end
      checks++;
      if (active_level !== 3'd0) begin errors++; $display("FAIL start_level: got %0d want 0", active_level); end
   endtask

   task automatic test_foreign_and_priority();
      level_lose[1] = 1'b1;
      level_win[2]  = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cycle();
         checks++;
         if (screen_mode !== 3'(PLAY)) begin errors++; $display("FAIL foreign_flags c=%0d: mode=%0d want %0d", c, screen_mode, PLAY); end
      end
      level_win = '0; level_lose = '0;
      level_win[0]  = 1'b1;
      level_lose[0] = 1'b1;
      cycle();
      level_win = '0; level_lose = '0;
      checks++;
      if ({screen_mode, lives, levels_cleared, level_reset_n, active_level} !== {3'(WIN), 3'(SL), 4'd1, 3'b000, 3'd0})
         begin errors++; $display("FAIL win_priority: mode=%0d lives=%0d clr=%0d rn=%b lvl=%0d want 3/%0d/1/000/0", screen_mode, lives, levels_cleared, level_reset_n, active_level, SL); end
      for (int c = 1; c <= SC; c++) begin
         cycle();
         checks++;
         if (screen_mode !== ((c < SC) ? 3'(WIN) : 3'(LOAD)) || level_reset_n !== 3'b000)
            begin errors++; $display("FAIL win_dwell c=%0d: mode=%0d rn=%b", c, screen_mode, level_reset_n); end
      end
      repeat (LC) cycle();
      checks++;
      if ({screen_mode, active_level, level_reset_n} !== {3'(PLAY), 3'd1, 3'b010})
         begin errors++; $display("FAIL next_level: mode=%0d lvl=%0d rn=%b want 2/1/010", screen_mode, active_level, level_reset_n); end
   endtask

   task automatic test_game_over();
      bit ok;
      for (int loss = 1; loss <= SL; loss++) begin
         cycle();
         level_lose[1] = 1'b1;
         cycle();
         level_lose = '0;
         checks++;
         if ({screen_mode, lives, active_level} !== {3'(LOSE), 3'(SL - loss), 3'd1})
            begin errors++; $display("FAIL loss%0d: mode=%0d lives=%0d lvl=%0d want 4/%0d/1", loss, screen_mode, lives, active_level, SL - loss); end
         repeat (SC) cycle();
         checks++;
         if (screen_mode !== ((loss < SL) ? 3'(LOAD) : 3'(GAME_OVER)) || active_level !== 3'd1)
            begin errors++; $display("FAIL after_loss%0d: mode=%0d lvl=%0d", loss, screen_mode, active_level); end
         if (loss < SL) begin
            wait_for_mode(3'(PLAY), LC + 2, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL replay_timeout: mode=%0d want %0d", screen_mode, PLAY); end
         end
      end
      checks++;
      if (level_reset_n !== 3'b000) begin errors++; $display("FAIL game_over_rn: got %b want 000", level_reset_n); end
      press_start();
      wait_for_mode(3'(TITLE), 6, ok);
      checks++;
      if (!ok || lives !== 3'(SL) || active_level !== 3'd0 || levels_cleared !== 4'd0)
         begin errors++; $display("FAIL go_to_title: mode=%0d lives=%0d lvl=%0d clr=%0d want 0/%0d/0/0", screen_mode, lives, active_level, levels_cleared, SL); end
   endtask

   task automatic test_first_cycle_guard();
      bit ok;
      press_start();
      wait_for_mode(3'(LOAD), 6, ok);
      wait_for_mode(3'(PLAY), LC + 2, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL guard_enter: mode=%0d want %0d", screen_mode, PLAY); end
      level_win[0]  = 1'b1;
      level_lose[0] = 1'b1;
      cycle();
      level_win = '0; level_lose = '0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (screen_mode !== 3'(PLAY) || lives !== 3'(SL) || levels_cleared !== 4'd0)
            begin errors++; $display("FAIL first_cycle_guard c=%0d: mode=%0d lives=%0d clr=%0d", c, screen_mode, lives, levels_cleared); end
         cycle();
      end
   endtask

   task automatic test_complete();
      bit ok;
      for (int lvl = 0; lvl < NL; lvl++) begin
         wait_for_mode(3'(PLAY), SC + LC + 4, ok);
         checks++;
         if (!ok || active_level !== 3'(lvl))
            begin errors++; $display("FAIL complete_play%0d: mode=%0d lvl=%0d", lvl, screen_mode, active_level); end
         cycle();
         level_win[lvl] = 1'b1;
         cycle();
         level_win = '0;
         checks++;
         if (screen_mode !== 3'(WIN) || levels_cleared !== 4'(lvl + 1))
            begin errors++; $display("FAIL complete_win%0d: mode=%0d clr=%0d want 3/%0d", lvl, screen_mode, levels_cleared, lvl + 1); end
         repeat (SC) cycle();
      end
      checks++;
      if ({screen_mode, levels_cleared, level_reset_n} !== {3'(COMPLETE), 4'd3, 3'b000})
         begin errors++; $display("FAIL complete: mode=%0d clr=%0d rn=%b want 6/3/000", screen_mode, levels_cleared, level_reset_n); end
      press_start();
      wait_for_mode(3'(TITLE), 6, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL complete_to_title: mode=%0d", screen_mode); end
   endtask

   task automatic test_random_games();
      bit            ok;
      bit            done;
      int            m_level, m_lives, m_cleared, r, extra;
      logic [2:0]    cur_mode, next_mode;
      logic [NL-1:0] onehot;
      for (int g = 0; g < 8; g++) begin
         m_level = 0; m_lives = SL; m_cleared = 0; done = 0;
         repeat (2) cycle();
         press_start();
         wait_for_mode(3'(LOAD), 6, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL rnd_start g=%0d: mode=%0d", g, screen_mode); end
         for (int round = 0; round < 20 && !done; round++) begin
            wait_for_mode(3'(PLAY), LC + 2, ok);
            onehot = NL'(1 << m_level);
            checks++;
            if (!ok || active_level !== 3'(m_level) || lives !== 3'(m_lives) || levels_cleared !== 4'(m_cleared) || level_reset_n !== onehot)
               begin errors++; $display("FAIL rnd_play g=%0d: mode=%0d lvl=%0d/%0d lives=%0d/%0d clr=%0d/%0d rn=%b/%b", g, screen_mode, active_level, m_level, lives, m_lives, levels_cleared, m_cleared, level_reset_n, onehot); end
            level_win  = NL'($urandom);
            level_lose = NL'($urandom);
            cycle();
            extra = $urandom_range(0, 3);
            for (int c = 0; c <= extra; c++) begin
               checks++;
               if (screen_mode !== 3'(PLAY)) begin errors++; $display("FAIL rnd_hold g=%0d c=%0d: mode=%0d want %0d", g, c, screen_mode, PLAY); end
               level_win  = NL'($urandom) & ~onehot;
               level_lose = NL'($urandom) & ~onehot;
               cycle();
            end
            r = $urandom_range(0, 2);
            level_win  = (NL'($urandom) & ~onehot) | ((r != 1) ? onehot : '0);
            level_lose = (NL'($urandom) & ~onehot) | ((r != 0) ? onehot : '0);
            cycle();
            level_win = '0; level_lose = '0;
            if (r != 1) begin
               m_cleared = (m_cleared < 15) ? m_cleared + 1 : 15;
               cur_mode  = 3'(WIN);
               if (m_level == NL - 1) begin next_mode = 3'(COMPLETE); done = 1; end
               else begin next_mode = 3'(LOAD); end
            end else begin
               m_lives  = m_lives - 1;
               cur_mode = 3'(LOSE);
               if (m_lives == 0) begin next_mode = 3'(GAME_OVER); done = 1; end
               else next_mode = 3'(LOAD);
            end
            checks++;
            if (screen_mode !== cur_mode || lives !== 3'(m_lives) || levels_cleared !== 4'(m_cleared))
               begin errors++; $display("FAIL rnd_outcome g=%0d: mode=%0d/%0d lives=%0d/%0d clr=%0d/%0d", g, screen_mode, cur_mode, lives, m_lives, levels_cleared, m_cleared); end
            for (int c = 1; c <= SC; c++) begin
               if (c == 1) start_button = 1'($urandom);
               cycle();
               start_button = 1'b0;
               checks++;
               if (screen_mode !== ((c < SC) ? cur_mode : next_mode))
                  begin errors++; $display("FAIL rnd_dwell g=%0d c=%0d: mode=%0d want %0d", g, c, screen_mode, (c < SC) ? cur_mode : next_mode); end
            end
            if (cur_mode == 3'(WIN) && !done) m_level++;
            checks++;
            if (active_level !== 3'(m_level)) begin errors++; $display("FAIL rnd_level g=%0d: got %0d want %0d", g, active_level, m_level); end
         end
         checks++;
         if (!done || level_reset_n !== 3'b000) begin errors++; $display("FAIL rnd_end g=%0d: done=%0d rn=%b", g, done, level_reset_n); end
         press_start();
         wait_for_mode(3'(TITLE), 6, ok);
         checks++;
         if (!ok || lives !== 3'(SL) || levels_cleared !== 4'd0)
            begin errors++; $display("FAIL rnd_title g=%0d: mode=%0d lives=%0d clr=%0d", g, screen_mode, lives, levels_cleared); end
      end
   endtask

   task automatic test_reset_mid_lose();
      bit ok;
      repeat (2) cycle();
      press_start();
      wait_for_mode(3'(LOAD), 6, ok);
      wait_for_mode(3'(PLAY), LC + 2, ok);
      cycle();
      level_lose[0] = 1'b1;
      cycle();
      level_lose = '0;
      checks++;
      if (screen_mode !== 3'(LOSE) || lives !== 3'(SL - 1))
         begin errors++; $display("FAIL mid_lose_enter: mode=%0d lives=%0d want 4/%0d", screen_mode, lives, SL - 1); end
      repeat (3) cycle();
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({screen_mode, active_level, lives, level_reset_n, levels_cleared} !== {3'(TITLE), 3'd0, 3'(SL), 3'b000, 4'd0})
         begin errors++; $display("FAIL async_reset: mode=%0d lvl=%0d lives=%0d rn=%b clr=%0d want 0/0/%0d/000/0", screen_mode, active_level, lives, level_reset_n, levels_cleared, SL); end
      cycle();
      reset = 1'b1;
      repeat (2) cycle();
      checks++;
      if (screen_mode !== 3'(TITLE)) begin errors++; $display("FAIL post_reset: mode=%0d want 0", screen_mode); end
   endtask

   initial begin
      test_reset();
      test_start_and_load();
      test_foreign_and_priority();
      test_game_over();
      test_first_cycle_guard();
      test_complete();
      test_random_games();
      test_reset_mid_lose();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
